// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot controller.
package imem_boot_pkg;

    // Boot sequencing states; LOAD must be the all-zero encoding.
    typedef enum logic [1:0] {
        LOAD = 2'd0,
        HOLD = 2'd1,
        RUN  = 2'd2
    } boot_state_t;

    // Width of the post-load core-reset hold counter (covers RST_HOLD up to 255).
    localparam int HOLD_CNT_W = 8;

endpackage

// File: rtl/imem_boot_hold_timer.sv
// Core-reset hold timer: cleared by load, counts while count is high,
// done flags the final cycle of an RST_HOLD-cycle window.
module boot_hold_timer
    import imem_boot_pkg::*;
#(
    parameter int RST_HOLD = 4
) (
    input  logic CLK,
    input  logic reset,
    input  logic load,
    input  logic count,
    output logic done
);

    localparam logic [HOLD_CNT_W-1:0] LAST_CNT = HOLD_CNT_W'(RST_HOLD - 1);

    logic [HOLD_CNT_W-1:0] cnt_reg;

    // Hold counter: restart on load, advance while the window is open.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= '0;
        end else if (count) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // Last cycle of the window is when the counter reaches RST_HOLD-1.
    always_comb begin
        done = count && (cnt_reg == LAST_CNT);
    end

endmodule

// File: rtl/imem_boot_ctrl.sv
// Instruction-memory boot controller: streams a program image from the
// loader into sequential memory words, holds the core in reset for
// RST_HOLD cycles, then releases it and hands the address bus to fetch.
// Optional feature macro: IMEM_RELOAD_EN adds a reload input that returns
// RUN to LOAD for a fresh image.
module imem_boot_ctrl
    import imem_boot_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 256,
    parameter int RST_HOLD = 4
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    input  logic [ADDR_W-1:0] core_imem_addr,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              core_reset,
    output logic              boot_done,
    output logic [ADDR_W:0]   load_count,
    output logic              err_overflow
`ifdef IMEM_RELOAD_EN
    ,
    input  logic              reload
`endif
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    boot_state_t       state_reg, state_next;
    logic [ADDR_W-1:0] addr_ptr_reg, addr_ptr_next;
    logic [ADDR_W:0]   load_count_reg, load_count_next;
    logic              err_overflow_reg, err_overflow_next;
    logic              hold_start;
    logic              hold_done;
    logic              handshake;
    logic              at_last;

    boot_hold_timer #(
        .RST_HOLD(RST_HOLD)
    ) u_hold_timer (
        .CLK  (CLK),
        .reset(reset),
        .load (hold_start),
        .count(state_reg == HOLD),
        .done (hold_done)
    );

    // State and load bookkeeping registers.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_reg        <= LOAD;
            addr_ptr_reg     <= '0;
            load_count_reg   <= '0;
            err_overflow_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            addr_ptr_reg     <= addr_ptr_next;
            load_count_reg   <= load_count_next;
            err_overflow_reg <= err_overflow_next;
        end
    end

    // Next-state logic: accept words in LOAD, time out HOLD, idle in RUN.
    always_comb begin
        state_next        = state_reg;
        addr_ptr_next     = addr_ptr_reg;
        load_count_next   = load_count_reg;
        err_overflow_next = err_overflow_reg;
        hold_start        = 1'b0;
        handshake         = (state_reg == LOAD) && ld_valid;
        at_last           = (addr_ptr_reg == LAST_ADDR);
        case (state_reg)
            LOAD: begin
                if (ld_valid) begin
                    load_count_next = load_count_reg + 1'b1;
                    // Pointer saturates on the final slot so a full-size
                    // memory never wraps back onto word 0.
                    if (!at_last) begin
                        addr_ptr_next = addr_ptr_reg + 1'b1;
                    end
                    if (ld_last || at_last) begin
                        state_next = HOLD;
                        hold_start = 1'b1;
                    end
                    if (at_last && !ld_last) begin
                        err_overflow_next = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (hold_done) begin
                    state_next = RUN;
                end
            end
            RUN: begin
`ifdef IMEM_RELOAD_EN
                if (reload) begin
                    state_next        = LOAD;
                    addr_ptr_next     = '0;
                    load_count_next   = '0;
                    err_overflow_next = 1'b0;
                end
`endif
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

    // Outputs: write strobe is combinational so the write lands in the
    // handshake cycle; reset forces it inactive even with ld_valid high.
    always_comb begin
        ld_ready     = (state_reg == LOAD);
        mem_wr       = ~(handshake & ~reset);
        mem_addr     = (state_reg == RUN) ? core_imem_addr : addr_ptr_reg;
        mem_wdata    = ld_data;
        core_reset   = (state_reg != RUN);
        boot_done    = (state_reg == RUN);
        load_count   = load_count_reg;
        err_overflow = err_overflow_reg;
    end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Scoreboard bench for imem_boot_ctrl: the driver pushes each expected
// memory write, a negedge monitor pops and compares on every mem_wr=0.
module tb_imem_boot_ctrl;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 32;
    localparam int DEPTH    = 8;
    localparam int RST_HOLD = 4;

    logic              CLK = 1'b0;
    logic              reset;
    logic              ld_valid;
    logic              ld_ready;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic [ADDR_W-1:0] core_imem_addr;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              core_reset;
    logic              boot_done;
    logic [ADDR_W:0]   load_count;
    logic              err_overflow;
`ifdef IMEM_RELOAD_EN
    logic              reload;
`endif

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [DATA_W-1:0] exp_data_q[$];
    logic [ADDR_W-1:0] mon_addr;
    logic [DATA_W-1:0] mon_data;

    imem_boot_ctrl #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .RST_HOLD(RST_HOLD)
    ) dut (
        .CLK           (CLK),
        .reset         (reset),
        .ld_valid      (ld_valid),
        .ld_ready      (ld_ready),
        .ld_data       (ld_data),
        .ld_last       (ld_last),
        .core_imem_addr(core_imem_addr),
        .mem_wr        (mem_wr),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .core_reset    (core_reset),
        .boot_done     (boot_done),
        .load_count    (load_count),
        .err_overflow  (err_overflow)
`ifdef IMEM_RELOAD_EN
        ,
        .reload        (reload)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge CLK) begin
        if (reset === 1'b0 && mem_wr !== 1'b1) begin
            if (exp_addr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: mem_wr=%b addr 0x%0h data 0x%0h, required no write",
                         mem_wr, mem_addr, mem_wdata);
            end else begin
                mon_addr = exp_addr_q.pop_front();
                mon_data = exp_data_q.pop_front();
                check("wr_addr", 64'(mem_addr), 64'(mon_addr));
                check("wr_data", 64'(mem_wdata), 64'(mon_data));
                $display("write addr=0x%0h data=0x%0h", mem_addr, mem_wdata);
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Assert reset off-edge, check reset values, release after a clock edge.
    task automatic do_reset();
        reset = 1'b1;
        #2;
        check("rst_ld_ready", 64'(ld_ready), 64'd1);
        check("rst_mem_wr", 64'(mem_wr), 64'd1);
        check("rst_core_reset", 64'(core_reset), 64'd1);
        check("rst_boot_done", 64'(boot_done), 64'd0);
        check("rst_load_count", 64'(load_count), 64'd0);
        check("rst_err_overflow", 64'(err_overflow), 64'd0);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        exp_addr_q.delete();
        exp_data_q.delete();
        @(posedge CLK);
        #1;
        reset = 1'b0;
        $display("reset applied");
    endtask

    // Offer an n-word image; stall_mode 0 = none, 1 = valid 1,0,0 pattern, 2 = random.
    task automatic run_image(input int n, input bit has_last, input int stall_mode, input bit fixed);
        int acc;
        bit ovf;
        int k;
        int phase;
        int hold;
        int extra;
        bit stall;
        logic [DATA_W-1:0] words[$];
        acc = (n < DEPTH) ? n : DEPTH;
        ovf = !(has_last && n <= DEPTH);
        for (int i = 0; i < n; i++) begin
            words.push_back(fixed ? DATA_W'(32'h11 * (i + 1)) : DATA_W'($urandom));
        end
        for (int i = 0; i < acc; i++) begin
            exp_addr_q.push_back(ADDR_W'(i));
            exp_data_q.push_back(words[i]);
        end
        k = 0;
        phase = 0;
        while (k < acc) begin
            if (stall_mode == 1) stall = (phase % 3) != 0;
            else if (stall_mode == 2) stall = ($urandom_range(99) < 30);
            else stall = 1'b0;
            phase++;
            if (stall) begin
                ld_valid = 1'b0;
                ld_data  = DATA_W'($urandom);
            end else begin
                check("ld_ready_load", 64'(ld_ready), 64'd1);
                ld_valid = 1'b1;
                ld_data  = words[k];
                ld_last  = has_last && (k == n - 1);
                k++;
            end
            step();
        end
        extra = n - acc;
        hold = 0;
        check("err_overflow_hold", 64'(err_overflow), 64'(ovf));
        while (core_reset === 1'b1 && hold < 40) begin
            if (extra > 0) begin
                check("ld_ready_hold", 64'(ld_ready), 64'd0);
                ld_valid = 1'b1;
                ld_data  = DATA_W'($urandom);
                ld_last  = 1'b0;
                extra--;
            end else begin
                ld_valid = 1'b0;
            end
            step();
            hold++;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        check("hold_cycles", 64'(hold), 64'(RST_HOLD));
        check("queue_drained", 64'(exp_addr_q.size()), 64'd0);
        check("boot_done", 64'(boot_done), 64'd1);
        check("load_count", 64'(load_count), 64'(acc));
        check("err_overflow", 64'(err_overflow), 64'(ovf));
        check("ld_ready_run", 64'(ld_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            core_imem_addr = (i == 0) ? ADDR_W'(8'h3C) : ADDR_W'($urandom);
            ld_valid = 1'b1;
            ld_data  = DATA_W'(32'hDEAD);
            #1;
            check("run_addr", 64'(mem_addr), 64'(core_imem_addr));
            check("run_mem_wr", 64'(mem_wr), 64'd1);
            check("run_core_reset", 64'(core_reset), 64'd0);
            step();
        end
        ld_valid = 1'b0;
        $display("image n=%0d last=%0d stall=%0d accepted=%0d ovf=%0d hold=%0d",
                 n, has_last, stall_mode, acc, ovf, hold);
    endtask

    initial begin
        reset          = 1'b1;
        ld_valid       = 1'b0;
        ld_data        = '0;
        ld_last        = 1'b0;
        core_imem_addr = '0;
`ifdef IMEM_RELOAD_EN
        reload         = 1'b0;
`endif
        do_reset();

        // Continuous 5-word image 0x11..0x55.
        run_image(5, 1'b1, 0, 1'b1);
        do_reset();

        // Same image with valid toggling 1,0,0,1...
        run_image(5, 1'b1, 1, 1'b1);
        do_reset();

        // DEPTH+2 words without ld_last: overflow.
        run_image(DEPTH + 2, 1'b0, 0, 1'b0);

`ifdef IMEM_RELOAD_EN
        reload = 1'b1;
        step();
        reload = 1'b0;
        check("reload_core_reset", 64'(core_reset), 64'd1);
        check("reload_err_clear", 64'(err_overflow), 64'd0);
        check("reload_count_clear", 64'(load_count), 64'd0);
        check("reload_boot_done", 64'(boot_done), 64'd0);
        $display("reload pulsed");
        run_image(2, 1'b1, 0, 1'b0);
`endif
        do_reset();

        // Abort mid-load after word 2, then a fresh 3-word image.
        exp_addr_q.push_back(ADDR_W'(0));
        exp_data_q.push_back(DATA_W'(32'hA0A0_0001));
        exp_addr_q.push_back(ADDR_W'(1));
        exp_data_q.push_back(DATA_W'(32'hA0A0_0002));
        ld_valid = 1'b1;
        ld_data  = DATA_W'(32'hA0A0_0001);
        step();
        ld_data  = DATA_W'(32'hA0A0_0002);
        step();
        ld_data  = DATA_W'(32'hA0A0_0003);
        check("abort_queue_drained", 64'(exp_addr_q.size()), 64'd0);
        check("abort_count_before", 64'(load_count), 64'd2);
        #2;
        do_reset();
        run_image(3, 1'b1, 2, 1'b0);
        do_reset();

        // Exactly DEPTH words with ld_last on the final one: no overflow.
        run_image(DEPTH, 1'b1, 0, 1'b0);
        do_reset();

        // Random images.
        for (int r = 0; r < 6; r++) begin
            run_image(int'($urandom_range(1, DEPTH)), 1'b1, 2, 1'b0);
            do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so a stuck run still reports.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/imem_boot_ctrl.md
Name: imem_boot_ctrl

Overview:
Parametrised instruction-memory boot controller between an external loader stream, the instruction memory and the RISC-V core fetch port. After reset it holds the core in reset and accepts a program image over a valid/ready stream. It writes each word to sequential memory addresses, then holds reset for a programmable number of cycles. It then releases the core and hands the memory address bus to core fetch. Supersedes the fixed 8-bit init-address mux: auto-incrementing addresses, handshake, core-reset sequencing, status outputs.

Parameters:
ADDR_W, 8, instruction-memory word-address width
DATA_W, 32, instruction word width
DEPTH, 256, maximum image length in words; legal range 1..2**ADDR_W
RST_HOLD, 4, cycles core_reset stays high after the last write; legal range 1..255

Ports:
CLK  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
ld_valid  input  1  loader word valid
ld_ready  output  1  controller can accept a word
ld_data  input  DATA_W  loader word
ld_last  input  1  qualifies the final word of the image; sampled only on handshake
core_imem_addr  input  ADDR_W  fetch address from the core
mem_wr  output  1  memory write strobe, active-low (0 = write this cycle)
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
core_reset  output  1  active-high reset to the core
boot_done  output  1  high in RUN
load_count  output  ADDR_W+1  number of words written by the current load
err_overflow  output  1  sticky: DEPTH words were written without ld_last

Behaviour:
- Clock: one clock, CLK. Reset: asynchronous, active-high, on port reset.
- Reset values: state=LOAD, addr_ptr=0, load_count=0, hold_cnt=0, err_overflow=0, core_reset=1, boot_done=0. Outputs during reset: ld_ready=1, mem_wr=1.
- Reset assertion mid-load or mid-run aborts immediately and returns to the reset values. Words already written stay in memory and are overwritten by the next load.
- LOAD state:
  - ld_ready=1 and core_reset=1.
  - mem_addr=addr_ptr, mem_wdata=ld_data.
  - mem_wr=~ld_valid (combinational), so the write happens in the same cycle as the handshake. Zero latency.
  - On handshake: addr_ptr++ and load_count++.
  - If ld_last=1, or addr_ptr==DEPTH-1, go to HOLD next cycle with hold_cnt=0.
  - If addr_ptr==DEPTH-1 and ld_last=0, set err_overflow. The DEPTH-th word is still written.
  - ld_valid=0: no write, no state change. Stalls of any length are legal.
- HOLD state:
  - ld_ready=0, mem_wr=1, mem_addr=addr_ptr, core_reset=1.
  - hold_cnt increments each cycle. When hold_cnt==RST_HOLD-1, go to RUN.
  - HOLD lasts exactly RST_HOLD cycles.
- RUN state:
  - ld_ready=0, mem_wr=1, mem_addr=core_imem_addr (combinational pass-through).
  - core_reset=0, boot_done=1. load_count is frozen.
  - RUN is terminal until reset (see the optional feature).
  - ld_valid in HOLD or RUN is ignored; no write occurs.
- Width rules: addr_ptr is ADDR_W bits and never wraps, because the transition to HOLD happens at DEPTH-1. load_count is ADDR_W+1 bits so that it can represent DEPTH=2**ADDR_W.
- mem_wdata in non-LOAD states: tracks ld_data. It is don't-care but must be X-free when ld_data is X-free.

Optional Feature:
Macro: IMEM_RELOAD_EN.
- Defined: adds input port reload (1 bit, after err_overflow).
  - A reload pulse sampled high in RUN moves to LOAD next cycle.
  - That transition clears addr_ptr, load_count and err_overflow, and asserts core_reset.
  - reload is ignored in LOAD and HOLD.
- Undefined: the port is absent and RUN is left only by reset.

Decomposition:
- Package imem_boot_pkg holds:
  - the state typedef (LOAD, HOLD, RUN; 2-bit encoding, LOAD=2'd0);
  - the localparam for the hold-counter width (8 bits).
- No sub-module is required. The HOLD counter may be split out as boot_hold_timer (load, count, done) if it is reused by the data-memory initialiser.

Test Plan:
- Reset then a 5-word image (0x11..0x55, ld_last on word 5), ld_valid continuous: mem_wr=0 on 5 consecutive cycles at addr 0..4 with matching data. load_count=5. core_reset falls exactly RST_HOLD=4 cycles after the last write. boot_done=1 and mem_addr follows core_imem_addr=0x3C.
- Same image with ld_valid toggling 1,0,0,1,...: writes only on valid cycles, addresses still contiguous 0..4, no write on stall cycles.
- DEPTH=4 and 6 words offered without ld_last: exactly 4 writes (addr 0..3), err_overflow=1 from the cycle after the 4th write, words 5–6 are never accepted (ld_ready=0), boot completes.
- Reset asserted asynchronously after word 2 of a load, then a new 3-word image: outputs return to reset values immediately; the new load writes addr 0..2; load_count=3.
- ld_valid=1 in RUN with data 0xDEAD: mem_wr stays 1 and mem_addr keeps tracking core_imem_addr.
- With IMEM_RELOAD_EN: in RUN pulse reload, then a 2-word image: core_reset rises the next cycle, writes land at addr 0..1, err_overflow is cleared, and the core is released again after RST_HOLD.
